// File: rtl/win_fetch_seq.sv
// Serial 3x3 neighbourhood fetch from a single-read-port image BRAM, one read per cycle.
// Define WIN_CENTER_EN to also fetch the centre pixel and expose it on o_pix_4.
module win_fetch_seq #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 96,
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [9:0]        i_req_x,
  input  logic [9:0]        i_req_y,
  output logic              o_req_ready,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_pix_0,
  output logic [7:0]        o_pix_1,
  output logic [7:0]        o_pix_2,
  output logic [7:0]        o_pix_3,
`ifdef WIN_CENTER_EN
  output logic [7:0]        o_pix_4,
`endif
  output logic [7:0]        o_pix_5,
  output logic [7:0]        o_pix_6,
  output logic [7:0]        o_pix_7,
  output logic [7:0]        o_pix_8,
  output logic              o_edge_flag
);

`ifdef WIN_CENTER_EN
  localparam int NREADS = 9;
`else
  localparam int NREADS = 8;
`endif
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_k;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [7:0]        r_pix [NREADS];
  logic              r_out_valid;
  logic              r_edge_flag;

  logic [3:0]        w_n;
  logic [1:0]        w_dy;
  logic [1:0]        w_dx;
  logic [9:0]        w_row;
  logic [9:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_border;
  logic              w_capture;
  logic [3:0]        w_slot;

  // Map read index k to neighbour number n; dy/dx are encoded 0/1/2 for -1/0/+1.
  always_comb begin
`ifdef WIN_CENTER_EN
    w_n = r_k;
`else
    w_n = (r_k >= 4'd4) ? r_k + 4'd1 : r_k;
`endif
    w_dy = 2'd2;
    w_dx = 2'd2;
    case (w_n)
      4'd0:    begin w_dy = 2'd0; w_dx = 2'd0; end
      4'd1:    begin w_dy = 2'd0; w_dx = 2'd1; end
      4'd2:    begin w_dy = 2'd0; w_dx = 2'd2; end
      4'd3:    begin w_dy = 2'd1; w_dx = 2'd0; end
      4'd4:    begin w_dy = 2'd1; w_dx = 2'd1; end
      4'd5:    begin w_dy = 2'd1; w_dx = 2'd2; end
      4'd6:    begin w_dy = 2'd2; w_dx = 2'd0; end
      4'd7:    begin w_dy = 2'd2; w_dx = 2'd1; end
      default: begin w_dy = 2'd2; w_dx = 2'd2; end
    endcase
  end

  assign w_row  = r_y + {8'd0, w_dy} - 10'd1;
  assign w_col  = r_x + {8'd0, w_dx} - 10'd1;
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(WIDTH) + ADDR_W'(w_col);

  assign w_border = (i_req_x == '0) || (i_req_x >= X_LAST) ||
                    (i_req_y == '0) || (i_req_y >= Y_LAST);

  // Data returned this cycle belongs to the read issued one cycle earlier.
  assign w_capture = ((r_state == FETCH) && (r_k != '0)) || (r_state == DRAIN);
  assign w_slot    = r_k - 4'd1;

  assign o_req_ready = (r_state == IDLE) && !i_rst;
  assign o_mem_en    = (r_state == FETCH);
  assign o_mem_addr  = o_mem_en ? w_addr : '0;
  assign o_out_valid = r_out_valid;
  assign o_edge_flag = r_edge_flag;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_edge_flag <= 1'b0;
      for (int i = 0; i < NREADS; i++) r_pix[i] <= '0;
    end else begin
      for (int i = 0; i < NREADS; i++) begin
        if (w_capture && (w_slot == 4'(i))) r_pix[i] <= i_mem_data;
      end
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_x <= i_req_x;
            r_y <= i_req_y;
            r_k <= '0;
            if (w_border) begin
              r_state     <= DONE;
              r_edge_flag <= 1'b1;
              r_out_valid <= 1'b1;
              for (int i = 0; i < NREADS; i++) r_pix[i] <= '0;
            end else begin
              r_state     <= FETCH;
              r_edge_flag <= 1'b0;
            end
          end
        end
        FETCH: begin
          r_k <= r_k + 4'd1;
          if (r_k == 4'(NREADS - 1)) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pix_0 = r_pix[0];
  assign o_pix_1 = r_pix[1];
  assign o_pix_2 = r_pix[2];
  assign o_pix_3 = r_pix[3];
`ifdef WIN_CENTER_EN
  assign o_pix_4 = r_pix[4];
  assign o_pix_5 = r_pix[5];
  assign o_pix_6 = r_pix[6];
  assign o_pix_7 = r_pix[7];
  assign o_pix_8 = r_pix[8];
`else
  assign o_pix_5 = r_pix[4];
  assign o_pix_6 = r_pix[5];
  assign o_pix_7 = r_pix[6];
  assign o_pix_8 = r_pix[7];
`endif

endmodule

// File: tb/tb_win_fetch_seq.sv
// Directed self-checking bench for win_fetch_seq; BRAM model returns addr[7:0] one cycle after a read.
// Honours WIN_CENTER_EN the same way as the design.
module tb_win_fetch_seq;

`ifdef WIN_CENTER_EN
  localparam int NREADS = 9;
`else
  localparam int NREADS = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic [9:0]  reqX = '0;
  logic [9:0]  reqY = '0;
  logic        reqReady;
  logic        memEn;
  logic [13:0] memAddr;
  logic [7:0]  memData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        edgeFlag;
  logic [7:0]  pix [NREADS];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int nAcc = 0;
  int accCyc [32];

  logic [31:0] addr53 [NREADS];
  logic [31:0] pix53  [NREADS];
  logic [31:0] addr11 [NREADS];
  logic [31:0] pix11  [NREADS];
  logic [31:0] zeros  [NREADS];

  win_fetch_seq #(.WIDTH(128), .HEIGHT(96), .ADDR_W(14)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .i_req_x(reqX), .i_req_y(reqY), .o_req_ready(reqReady),
    .o_mem_en(memEn), .o_mem_addr(memAddr), .i_mem_data(memData),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_pix_0(pix[0]), .o_pix_1(pix[1]), .o_pix_2(pix[2]), .o_pix_3(pix[3]),
`ifdef WIN_CENTER_EN
    .o_pix_4(pix[4]),
    .o_pix_5(pix[5]), .o_pix_6(pix[6]), .o_pix_7(pix[7]), .o_pix_8(pix[8]),
`else
    .o_pix_5(pix[4]), .o_pix_6(pix[5]), .o_pix_7(pix[6]), .o_pix_8(pix[7]),
`endif
    .o_edge_flag(edgeFlag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (memEn) memData <= memAddr[7:0];
    if (reqValid && reqReady) begin
      if (nAcc < 32) accCyc[nAcc] <= cycle;
      nAcc <= nAcc + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    reqValid = 1'b1;
    reqX = x;
    reqY = y;
  endtask

  task automatic checkPix(input string tag, input logic [31:0] exp [NREADS]);
    for (int i = 0; i < NREADS; i++) checkOutput({tag, "_pix"}, 32'(pix[i]), exp[i]);
  endtask

  // Accept an interior request, then follow the read stream, drain cycle and finished window.
  task automatic fetchWindow(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [31:0] ea [NREADS], input logic [31:0] ep [NREADS]);
    applyStimulus(x, y);
    @(negedge clk);
    reqValid = 1'b0;
    for (int k = 0; k < NREADS; k++) begin
      checkOutput({tag, "_memEn"}, 32'(memEn), 32'd1);
      checkOutput({tag, "_addr"}, 32'(memAddr), ea[k]);
      checkOutput({tag, "_validEarly"}, 32'(outValid), 32'd0);
      @(negedge clk);
    end
    checkOutput({tag, "_drainMemEn"}, 32'(memEn), 32'd0);
    checkOutput({tag, "_drainAddr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_drainValid"}, 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_outValid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_edge"}, 32'(edgeFlag), 32'd0);
    checkPix(tag, ep);
  endtask

  task automatic borderWindow(input logic [9:0] x, input logic [9:0] y);
    applyStimulus(x, y);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("border_outValid", 32'(outValid), 32'd1);
    checkOutput("border_edge", 32'(edgeFlag), 32'd1);
    checkOutput("border_memEn", 32'(memEn), 32'd0);
    checkOutput("border_ready", 32'(reqReady), 32'd0);
    checkPix("border", zeros);
  endtask

  initial begin
    logic [9:0]  b2bX [4];
    logic [9:0]  b2bY [4];
    logic [31:0] b2bAddr [2*NREADS];
    int startAcc;
    int reqIdx;
    int addrIdx;

`ifdef WIN_CENTER_EN
    addr53 = '{260, 261, 262, 388, 389, 390, 516, 517, 518};
    pix53  = '{'h04, 'h05, 'h06, 'h84, 'h85, 'h86, 'h04, 'h05, 'h06};
    addr11 = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
    pix11  = '{'h00, 'h01, 'h02, 'h80, 'h81, 'h82, 'h00, 'h01, 'h02};
`else
    addr53 = '{260, 261, 262, 388, 390, 516, 517, 518};
    pix53  = '{'h04, 'h05, 'h06, 'h84, 'h86, 'h04, 'h05, 'h06};
    addr11 = '{0, 1, 2, 128, 130, 256, 257, 258};
    pix11  = '{'h00, 'h01, 'h02, 'h80, 'h82, 'h00, 'h01, 'h02};
`endif
    for (int i = 0; i < NREADS; i++) begin
      zeros[i] = 32'd0;
      b2bAddr[i] = addr53[i];
      b2bAddr[NREADS + i] = addr11[i];
    end
    b2bX = '{10'd5, 10'd0, 10'd1, 10'd10};
    b2bY = '{10'd3, 10'd10, 10'd1, 10'd95};

    // Reset values
    @(negedge clk);
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_memEn", 32'(memEn), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_edge", 32'(edgeFlag), 32'd0);
    checkPix("rst", zeros);
    rst = 1'b0;
    #1;
    checkOutput("idle_ready", 32'(reqReady), 32'd1);

    // Interior (5,3) with the consumer stalling for 6 cycles
    outReady = 1'b0;
    fetchWindow("win53", 10'd5, 10'd3, addr53, pix53);
    reqValid = 1'b1;
    reqX = 10'd10;
    reqY = 10'd10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("hold_outValid", 32'(outValid), 32'd1);
      checkOutput("hold_ready", 32'(reqReady), 32'd0);
      checkOutput("hold_memEn", 32'(memEn), 32'd0);
      checkOutput("hold_edge", 32'(edgeFlag), 32'd0);
      checkPix("hold", pix53);
    end
    outReady = 1'b1;
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("release_outValid", 32'(outValid), 32'd0);
    checkOutput("release_ready", 32'(reqReady), 32'd1);
    checkOutput("release_noFetch", 32'(memEn), 32'd0);

    // Reset in the middle of an interior fetch, then a clean (1,1) window
    applyStimulus(10'd5, 10'd3);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midfetch_memEn", 32'(memEn), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_memEn", 32'(memEn), 32'd0);
    checkOutput("abort_addr", 32'(memAddr), 32'd0);
    checkOutput("abort_outValid", 32'(outValid), 32'd0);
    checkOutput("abort_ready", 32'(reqReady), 32'd0);
    checkPix("abort", zeros);
    @(negedge clk);
    rst = 1'b0;
    fetchWindow("win11", 10'd1, 10'd1, addr11, pix11);

    // Border and out-of-range coordinates
    borderWindow(10'd0, 10'd10);
    borderWindow(10'd127, 10'd10);
    borderWindow(10'd10, 10'd0);
    borderWindow(10'd10, 10'd95);
    borderWindow(10'd200, 10'd300);

    // Back-to-back requests, interior and border alternating, consumer always ready
    startAcc = nAcc;
    reqIdx = 0;
    addrIdx = 0;
    reqX = b2bX[0];
    reqY = b2bY[0];
    reqValid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (memEn) begin
        if (addrIdx < 2*NREADS) checkOutput("b2b_addr", 32'(memAddr), b2bAddr[addrIdx]);
        else checkOutput("b2b_extraRead", 32'(memEn), 32'd0);
        addrIdx++;
      end
      if ((nAcc - startAcc) > reqIdx) begin
        reqIdx++;
        if (reqIdx < 4) begin
          reqX = b2bX[reqIdx];
          reqY = b2bY[reqIdx];
        end else begin
          reqValid = 1'b0;
        end
      end
    end
    checkOutput("b2b_accepts", 32'(nAcc - startAcc), 32'd4);
    checkOutput("b2b_reads", 32'(addrIdx), 32'(2*NREADS));
    if ((nAcc - startAcc) >= 4) begin
      checkOutput("b2b_gapInterior", 32'(accCyc[startAcc+1] - accCyc[startAcc]), 32'(NREADS + 3));
      checkOutput("b2b_gapBorder", 32'(accCyc[startAcc+2] - accCyc[startAcc+1]), 32'd2);
      checkOutput("b2b_gapInterior2", 32'(accCyc[startAcc+3] - accCyc[startAcc+2]), 32'(NREADS + 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
